// File: rtl/cp0_pkg.sv
// cp0_pkg: shared register numbers, exception codes and field positions for coprocessor 0
package cp0_pkg;
   localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int IM_LO    = 10;
   localparam int IM_HI    = 15;
   localparam int CAUSE_BD = 31;
   localparam int EXC_LO   = 2;
   localparam int EXC_HI   = 6;
   typedef enum logic {USER, KERNEL} mode_e;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and sticky timer-pending flag
module cp0_timer
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        pending
);
   logic wr_cmp;
   assign wr_cmp = we && addr == REG_COMPARE;
   // count every cycle, latch a match until Compare is rewritten
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         count   <= '0;
         compare <= '0;
         pending <= 1'b0;
      end else begin
         count   <= (we && addr == REG_COUNT) ? wdata : count + 32'd1;
         compare <= wr_cmp ? wdata : compare;
         pending <= wr_cmp ? 1'b0 : pending | (count == compare && compare != '0);
      end
endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: exception/interrupt controller and SR/Cause/EPC/PRId file; timer built when CP0_TIMER_EN is defined
module cp0_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
   parameter logic [31:0] PRID_VAL   = 32'h2021_0607
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic [31:0] m_pc,
   input  logic        m_bd,
   input  logic [4:0]  m_exccode,
   input  logic        eret,
   input  logic [5:0]  hw_int,
   output logic        int_req,
   output logic [31:0] epc_out
);
   if (HANDLER_PC[1:0] != 2'b00) begin : g_bad_handler
      $error("HANDLER_PC must be word aligned");
   end
   mode_e       mode;
   logic [5:0]  im, ip, ip_next;
   logic        ie, bd, exl, irq, exc, wr, tmr_pend;
   logic [4:0]  exccode;
   logic [31:0] epc, count, compare, sr_word, cause_word;
`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .clk(clk), .reset(reset), .we(wr), .addr(cp0_addr), .wdata(cp0_wdata),
      .count(count), .compare(compare), .pending(tmr_pend)
   );
`else
   assign count    = '0;
   assign compare  = '0;
   assign tmr_pend = 1'b0;
`endif
   assign exl        = mode == KERNEL;
   assign ip_next    = {hw_int[5] | tmr_pend, hw_int[4:0]};
   assign irq        = ie & ~exl & |(ip_next & im);
   assign exc        = ~exl & |m_exccode;
   assign int_req    = ~reset & (irq | exc);
   assign wr         = we & ~int_req;
   assign epc_out    = reset ? '0 : (we && cp0_addr == REG_EPC) ? cp0_wdata : epc;
   assign sr_word    = {16'b0, im, 8'b0, exl, ie};
   assign cause_word = {bd, 15'b0, ip, 3'b0, exccode, 2'b0};
   // mfc0 read mux, no same-cycle bypass
   always_comb
      cp0_rdata = cp0_addr == REG_SR      ? sr_word    :
                  cp0_addr == REG_CAUSE   ? cause_word :
                  cp0_addr == REG_EPC     ? epc        :
                  cp0_addr == REG_PRID    ? PRID_VAL   :
                  cp0_addr == REG_COUNT   ? count      :
                  cp0_addr == REG_COMPARE ? compare    : '0;
   // USER/KERNEL mode plus SR, Cause and EPC; a trap flushes any mtc0 and overrides eret
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         mode    <= USER;
         ie      <= 1'b0;
         im      <= '0;
         ip      <= '0;
         bd      <= 1'b0;
         exccode <= '0;
         epc     <= '0;
      end else begin
         ip <= ip_next;
         if (int_req) begin
            mode    <= KERNEL;
            bd      <= m_bd;
            exccode <= irq ? EXC_INT : m_exccode;
            epc     <= m_bd ? m_pc - 32'd4 : m_pc;
         end else begin
            if (we && cp0_addr == REG_SR) begin
               im   <= cp0_wdata[IM_HI:IM_LO];
               ie   <= cp0_wdata[SR_IE];
               mode <= cp0_wdata[SR_EXL] ? KERNEL : USER;
            end
            if (eret) mode <= USER;
            if (we && cp0_addr == REG_EPC) epc <= cp0_wdata;
         end
      end
endmodule
